// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl
//   Hazard controller for the execute stage of a 5-stage pipeline. It tracks
//   the destination registers of the instructions in flight in EX and MEM. From
//   them it raises fetch/decode stalls on load-use hazards (or on any RAW hazard
//   when forwarding is disabled). It kills younger instructions on a taken
//   branch/jump, and it registers the ALU operand forwarding selects together
//   with the instruction entering EX.
//
// Parameters
//   REG_W   register specifier width
//   FWD_EN  1: forward from EX/MEM and MEM/WB; 0: no forwarding, stall instead
//   CNT_W   width of the stall performance counter
//
// Ports
//   sysclk          in   system clock, rising edge
//   rst             in   asynchronous active-low reset
//   id_valid        in   decode holds a valid instruction
//   id_rs_rd/id_rs  in   first source used / specifier
//   id_rt_rd/id_rt  in   second source used / specifier
//   id_wr_en        in   decode instruction writes id_wr_reg
//   id_wr_reg       in   destination specifier
//   id_is_load      in   decode instruction is a load
//   ex_brjmp_taken  in   execute redirects the PC this cycle
//   mem_stall       in   memory busy, whole pipeline freezes
//   stall_fetch     out  hold PC and IF/ID
//   stall_decode    out  hold decode outputs
//   flush_if_id     out  invalidate IF/ID at next edge
//   flush_id_ex     out  load a bubble into ID/EX at next edge
//   fwd_a, fwd_b    out  ALU operand source: 00 reg file, 01 EX/MEM, 10 WB
//   ex_valid        out  EX slot holds a real instruction
//   stall_cnt       out  saturating count of hazard-stall cycles

module ex_hazard_ctrl #(
    parameter int REG_W  = 3,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_rs_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic             id_rt_rd,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_wr_en,
    input  logic [REG_W-1:0] id_wr_reg,
    input  logic             id_is_load,
    input  logic             ex_brjmp_taken,
    input  logic             mem_stall,
    output logic             stall_fetch,
    output logic             stall_decode,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             ex_valid,
    output logic [CNT_W-1:0] stall_cnt
);

    // EX slot: valid is ex_valid; the rest is only meaningful when valid.
    logic             ex_wr_en;
    logic [REG_W-1:0] ex_wr_reg;
    logic             ex_is_load;

    // MEM slot: valid and wr_en folded together, is_load is never consulted
    // once an instruction leaves EX. The WB slot is not kept at all: the
    // register file bypasses WB writes to decode, so a WB producer can neither
    // stall nor need a forwarding select.
    logic             mem_wr;
    logic [REG_W-1:0] mem_wr_reg;

    logic       rs_ex, rt_ex, rs_mem, rt_mem;
    logic       hz;
    logic       issue;
    logic [1:0] fwd_a_nxt, fwd_b_nxt;

    // The youngest producer wins: an EX hit (ALU result in EX/MEM next cycle)
    // beats a MEM hit (value on the WB bus next cycle).
    function automatic logic [1:0] fwd_sel(input logic en, input logic ex_hit,
                                           input logic mem_hit, input logic ex_load);
        logic [1:0] sel;
        sel = 2'b00;
        if (en && (FWD_EN != 0)) begin
            if (ex_hit && !ex_load)
                sel = 2'b01;
            else if (mem_hit)
                sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        rs_ex  = id_rs_rd & ex_valid & ex_wr_en & (id_rs == ex_wr_reg);
        rt_ex  = id_rt_rd & ex_valid & ex_wr_en & (id_rt == ex_wr_reg);
        rs_mem = id_rs_rd & mem_wr & (id_rs == mem_wr_reg);
        rt_mem = id_rt_rd & mem_wr & (id_rt == mem_wr_reg);

        if (FWD_EN != 0)
            hz = id_valid & (rs_ex | rt_ex) & ex_is_load;
        else
            hz = id_valid & (rs_ex | rt_ex | rs_mem | rt_mem);

        issue        = id_valid & ~hz & ~ex_brjmp_taken & ~mem_stall;
        // A redirect makes the stalled instruction dead, so it must not hold fetch.
        stall_fetch  = mem_stall | (hz & ~ex_brjmp_taken);
        stall_decode = stall_fetch;
        flush_if_id  = ex_brjmp_taken & ~mem_stall;
        flush_id_ex  = ~mem_stall & ~issue;

        fwd_a_nxt = fwd_sel(issue, rs_ex, rs_mem, ex_is_load);
        fwd_b_nxt = fwd_sel(issue, rt_ex, rt_mem, ex_is_load);
    end

    // ID -> EX -> MEM slot advance, control part
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            ex_valid  <= 1'b0;
            mem_wr    <= 1'b0;
            fwd_a     <= 2'b00;
            fwd_b     <= 2'b00;
            stall_cnt <= '0;
        end else if (!mem_stall) begin
            ex_valid <= issue;
            mem_wr   <= ex_valid & ex_wr_en;
            fwd_a    <= fwd_a_nxt;
            fwd_b    <= fwd_b_nxt;
            if (hz && !ex_brjmp_taken && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // ID -> EX -> MEM slot advance, payload part (qualified by the valid bits)
    always_ff @(posedge sysclk) begin
        if (!mem_stall) begin
            ex_wr_en   <= id_wr_en;
            ex_wr_reg  <= id_wr_reg;
            ex_is_load <= id_is_load;
            mem_wr_reg <= ex_wr_reg;
        end
    end

endmodule
